// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: queues host opcodes and issues them one at a time
// to the LCD image controller under its busy/done handshake.
module lcd_cmd_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [3:0]                  host_cmd,
   input  logic                        host_push,
   output logic                        host_full,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [3:0]                  lcd_cmd,
   output logic                        lcd_cmd_valid,
   input  logic                        lcd_busy,
   input  logic                        lcd_done,
   output logic [7:0]                  issued_cnt,
   output logic                        seq_done,
   output logic                        err_illegal,
   output logic                        err_timeout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TLIM     = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      ISSUE,
      WAIT_ACK,
      WAIT_REL,
      FINISH,
      HALT
   } state_t;

   state_t        state;
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_nxt;
   logic [TW-1:0] timer;
   logic [3:0]    head;
   logic          push;
   logic          pop;

   assign head = mem[rd_ptr];
   assign push = host_push && !host_full;
   assign pop  = (state == ARMED) && !lcd_busy && (fifo_level != '0);

   always_comb begin
      level_nxt = fifo_level;
      if (push && !pop) begin
         level_nxt = fifo_level + (AW+1)'(1);
      end else if (pop && !push) begin
         level_nxt = fifo_level - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= host_cmd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         host_full  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_level <= level_nxt;
         host_full  <= (level_nxt == FULL_LVL);
      end
   end

   // lcd_cmd holds the last issued opcode, so it doubles as the
   // record of which command the handshake belongs to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         lcd_cmd       <= '0;
         lcd_cmd_valid <= 1'b0;
         issued_cnt    <= '0;
         seq_done      <= 1'b0;
         err_illegal   <= 1'b0;
         err_timeout   <= 1'b0;
         timer         <= '0;
      end else begin
         lcd_cmd_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (pop) begin
                  if (head > 4'd11) begin
                     err_illegal <= 1'b1;
                  end else begin
                     state         <= ISSUE;
                     lcd_cmd       <= head;
                     lcd_cmd_valid <= 1'b1;
                     if (issued_cnt != 8'hff) begin
                        issued_cnt <= issued_cnt + 8'd1;
                     end
                  end
               end
            end
            ISSUE: begin
               state <= WAIT_ACK;
               timer <= '0;
            end
            WAIT_ACK: begin
               if (lcd_busy) begin
                  state <= WAIT_REL;
                  timer <= '0;
               end else if (timer == TLIM) begin
                  err_timeout <= 1'b1;
                  state       <= HALT;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_REL: begin
               if (!lcd_busy) begin
                  if (lcd_cmd != 4'd0) begin
                     state <= ARMED;
                  end else if (lcd_done) begin
                     seq_done <= 1'b1;
                     state    <= FINISH;
                  end
               end else if (lcd_cmd != 4'd0) begin
                  // the acknowledging busy cycle already counted as one
                  if (timer == TLIM) begin
                     err_timeout <= 1'b1;
                     state       <= HALT;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
            end
            FINISH, HALT: begin
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
